axi_store_master: RTL and testbench
===================================

# axi_store_master

Single-outstanding AXI4 write master for the core's data-store path. Accepts one store request at a time from the MEM stage, issues the single-beat AW and W transfers, waits for the B response, and reports completion or error back to the pipeline. It is the write-side counterpart of the instruction-fetch read master and drives the top-level `m_axi_aw*`, `m_axi_w*` and `m_axi_b*` ports.

## Interface
- `ID_WIDTH`, 13, AXI ID width
- `ADDR_WIDTH`, 64, AXI address width
- `DATA_WIDTH`, 64, AXI data width (only 64 supported)
- `STRB_WIDTH`, DATA_WIDTH/8, write-strobe width
- `AXI_ID`, 0, constant value driven on `m_axi_awid`

- `clk`  in  1  sole clock
- `reset`  in  1  asynchronous, active-low reset
- `st_valid`  in  1  store request valid
- `st_ready`  out  1  block can accept a request
- `st_addr`  in  64  byte address
- `st_data`  in  64  store data, right-justified (bits [8·2^size-1:0] significant)
- `st_size`  in  2  0=byte, 1=half, 2=word, 3=dword
- `st_done`  out  1  one-cycle completion pulse
- `st_err`  out  1  valid with `st_done`; misaligned address or SLVERR/DECERR
- `m_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid`  out  per AXI  write address
- `m_axi_awready`  in  1
- `m_axi_wdata/wstrb/wlast/wvalid`  out  per AXI  write data
- `m_axi_wready`  in  1
- `m_axi_bid`  in  ID_WIDTH; `m_axi_bresp`  in  2; `m_axi_bvalid`  in  1
- `m_axi_bready`  out  1

## Operation
- States: IDLE, SEND, RESP, DONE.
- IDLE: `st_ready`=1. On `st_valid`: latch addr/data/size. If address not aligned to 2^size → DONE with err=1, no bus traffic. Else → SEND.
- SEND: `awvalid` and `wvalid` asserted independently; each drops after its own handshake (`valid&ready`), never re-raised. When both have completed (same or different cycles) → RESP.
- RESP: `bready`=1. On `bvalid` → DONE, err = `bresp[1]`. `bid` not checked.
- DONE: `st_done`=1 for one cycle, `st_err` as latched → IDLE.
- Fixed fields: `awlen`=0, `awburst`=INCR (01), `awsize`={0,latched size}, `awlock`=0, `awcache`=0, `awprot`=0, `wlast`=1, `awid`=AXI_ID.
- `awaddr` = latched address, unmodified.
- Lane alignment: `wdata` = data << (8·addr[2:0]); `wstrb` = ((1<<2^size)-1) << addr[2:0]. Bits outside the size field are don't-care on input, zeroed on `wdata`.
- AW/W payload held stable while the respective valid is high.

## Timing
- Reset (async assert, sync release): state IDLE; `st_ready`=1; `st_done`, `st_err`, `awvalid`, `wvalid`, `bready`=0; payload registers 0.
- Reset asserted mid-transaction: valids drop immediately, transaction abandoned, no `st_done`.
- Accept at edge N → `awvalid`/`wvalid` high in cycle N+1.
- Minimum latency (ready slaves, `bvalid` one cycle after W): accept N, AW/W handshake N+1, B handshake N+2, `st_done` N+3, `st_ready` high again N+4.
- Misaligned: accept N, `st_done`+`st_err` in N+1.
- `st_ready` is low in every state except IDLE; no request is accepted while `st_done` is high.
- `bvalid` arriving before both AW and W are done is not accepted (`bready`=0).

## Structure
- Package `axi_pkg`: burst encodings (FIXED/INCR/WRAP), response encodings (OKAY/EXOKAY/SLVERR/DECERR), `store_size_e` enum, state enum.
- Sub-module `axi_wstrb_gen`: combinational lane shift and strobe generation from addr[2:0] and size; also outputs the misalignment flag.

## Test plan
- SB 0xAB to 0x1003, ready slave → `wstrb`=0x08, `wdata`=0x00000000AB000000, `awsize`=0, `st_done` 3 cycles after accept, `st_err`=0.
- SD 0x1122334455667788 to 0x2000, `awready` held low 4 cycles, `wready` immediate → `wvalid` drops after 1 cycle, `awvalid` held with stable address, RESP entered only after AW handshake.
- SW to 0x1002 → no `awvalid`/`wvalid` ever, `st_done`=`st_err`=1 in cycle after accept.
- SH 0xBEEF to 0x3006, `bresp`=SLVERR → `wstrb`=0xC0, `st_err`=1 with `st_done`.
- Back-to-back requests with `st_valid` held high → second accepted only in IDLE after first `st_done`; two AW handshakes total.
- Reset asserted while in SEND with `awvalid` high → `awvalid`/`wvalid` low immediately, `st_ready`=1 after release, no `st_done`.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and store-master types.
package axi_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    SizeByte  = 2'd0,
    SizeHalf  = 2'd1,
    SizeWord  = 2'd2,
    SizeDword = 2'd3
  } store_size_e;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StResp,
    StDone
  } store_state_e;

  // Low address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] size_align_mask(store_size_e size);
    unique case (size)
      SizeByte:  size_align_mask = 3'b000;
      SizeHalf:  size_align_mask = 3'b001;
      SizeWord:  size_align_mask = 3'b011;
      SizeDword: size_align_mask = 3'b111;
      default:   size_align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/axi_wstrb_gen.sv
// Places right-justified store data onto its byte lanes and builds the write strobe.
module axi_wstrb_gen
  import axi_pkg::*;
(
  input  logic [2:0]  addr_off_i,
  input  store_size_e size_i,
  input  logic [63:0] data_i,
  output logic [63:0] wdata_o,
  output logic [7:0]  wstrb_o,
  output logic        misaligned_o
);

  logic [63:0] data_mask;
  logic [7:0]  strb_base;

  always_comb begin
    data_mask = '0;
    strb_base = '0;
    unique case (size_i)
      SizeByte: begin
        data_mask = 64'h0000_0000_0000_00ff;
        strb_base = 8'h01;
      end
      SizeHalf: begin
        data_mask = 64'h0000_0000_0000_ffff;
        strb_base = 8'h03;
      end
      SizeWord: begin
        data_mask = 64'h0000_0000_ffff_ffff;
        strb_base = 8'h0f;
      end
      SizeDword: begin
        data_mask = 64'hffff_ffff_ffff_ffff;
        strb_base = 8'hff;
      end
      default: begin
        data_mask = '0;
        strb_base = '0;
      end
    endcase
  end

  assign misaligned_o = |(addr_off_i & size_align_mask(size_i));
  // Unused upper bits are cleared before the shift so they never reach the bus.
  assign wdata_o      = (data_i & data_mask) << {addr_off_i, 3'b000};
  assign wstrb_o      = strb_base << addr_off_i;

endmodule

// File: rtl/axi_store_master.sv
// Single-outstanding AXI4 write master for the data-store path: one AW, one W, one B per store.
module axi_store_master
  import axi_pkg::*;
#(
  parameter int unsigned        ID_WIDTH   = 13,
  parameter int unsigned        ADDR_WIDTH = 64,
  parameter int unsigned        DATA_WIDTH = 64,
  parameter int unsigned        STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [ID_WIDTH-1:0] AXI_ID    = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  st_valid_i,
  output logic                  st_ready_o,
  input  logic [ADDR_WIDTH-1:0] st_addr_i,
  input  logic [DATA_WIDTH-1:0] st_data_i,
  input  logic [1:0]            st_size_i,
  output logic                  st_done_o,
  output logic                  st_err_o,

  output logic [ID_WIDTH-1:0]   m_axi_awid_o,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr_o,
  output logic [7:0]            m_axi_awlen_o,
  output logic [2:0]            m_axi_awsize_o,
  output logic [1:0]            m_axi_awburst_o,
  output logic                  m_axi_awlock_o,
  output logic [3:0]            m_axi_awcache_o,
  output logic [2:0]            m_axi_awprot_o,
  output logic                  m_axi_awvalid_o,
  input  logic                  m_axi_awready_i,

  output logic [DATA_WIDTH-1:0] m_axi_wdata_o,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb_o,
  output logic                  m_axi_wlast_o,
  output logic                  m_axi_wvalid_o,
  input  logic                  m_axi_wready_i,

  input  logic [ID_WIDTH-1:0]   m_axi_bid_i,
  input  logic [1:0]            m_axi_bresp_i,
  input  logic                  m_axi_bvalid_i,
  output logic                  m_axi_bready_o
);

  store_state_e          state_q;
  logic                  st_ready_q;
  logic                  st_done_q;
  logic                  st_err_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  store_size_e           awsize_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  logic [63:0] lane_wdata;
  logic [7:0]  lane_wstrb;
  logic        misaligned;
  logic        aw_hs;
  logic        w_hs;
  logic        aw_clear;
  logic        w_clear;

  axi_wstrb_gen u_wstrb_gen (
    .addr_off_i   (st_addr_i[2:0]),
    .size_i       (store_size_e'(st_size_i)),
    .data_i       (st_data_i),
    .wdata_o      (lane_wdata),
    .wstrb_o      (lane_wstrb),
    .misaligned_o (misaligned)
  );

  assign aw_hs    = awvalid_q & m_axi_awready_i;
  assign w_hs     = wvalid_q & m_axi_wready_i;
  // A channel is finished once its valid has dropped or is handshaking this cycle.
  assign aw_clear = ~awvalid_q | m_axi_awready_i;
  assign w_clear  = ~wvalid_q | m_axi_wready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      st_ready_q <= 1'b1;
      st_done_q  <= 1'b0;
      st_err_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      awaddr_q   <= '0;
      awsize_q   <= SizeByte;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      st_done_q <= 1'b0;
      st_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (st_valid_i) begin
            awaddr_q   <= st_addr_i;
            awsize_q   <= store_size_e'(st_size_i);
            wdata_q    <= lane_wdata;
            wstrb_q    <= lane_wstrb;
            st_ready_q <= 1'b0;
            if (misaligned) begin
              state_q   <= StDone;
              st_done_q <= 1'b1;
              st_err_q  <= 1'b1;
            end else begin
              state_q   <= StSend;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end
          end
        end
        StSend: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs) wvalid_q <= 1'b0;
          if (aw_clear && w_clear) begin
            state_q  <= StResp;
            bready_q <= 1'b1;
          end
        end
        StResp: begin
          if (m_axi_bvalid_i) begin
            state_q   <= StDone;
            bready_q  <= 1'b0;
            st_done_q <= 1'b1;
            st_err_q  <= m_axi_bresp_i[1];
          end
        end
        StDone: begin
          state_q    <= StIdle;
          st_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= StIdle;
          st_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // The B ID is not checked and only bresp[1] distinguishes error responses.
  logic unused_b;
  assign unused_b = ^{m_axi_bid_i, m_axi_bresp_i[0]};

  assign st_ready_o      = st_ready_q;
  assign st_done_o       = st_done_q;
  assign st_err_o        = st_err_q;

  assign m_axi_awid_o    = AXI_ID;
  assign m_axi_awaddr_o  = awaddr_q;
  assign m_axi_awlen_o   = 8'd0;
  assign m_axi_awsize_o  = {1'b0, awsize_q};
  assign m_axi_awburst_o = BurstIncr;
  assign m_axi_awlock_o  = 1'b0;
  assign m_axi_awcache_o = 4'd0;
  assign m_axi_awprot_o  = 3'd0;
  assign m_axi_awvalid_o = awvalid_q;

  assign m_axi_wdata_o   = wdata_q;
  assign m_axi_wstrb_o   = wstrb_q;
  assign m_axi_wlast_o   = 1'b1;
  assign m_axi_wvalid_o  = wvalid_q;

  assign m_axi_bready_o  = bready_q;

endmodule

// File: tb/tb_axi_store_master.sv
// Randomized bench for axi_store_master with a byte-lane reference model and a cycle-level slave.
module tb_axi_store_master;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic [1:0]  st_size;
  logic        st_done;
  logic        st_err;
  logic [12:0] awid;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [12:0] bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int n_checks = 0;
  int n_fail   = 0;

  int          last_done_cyc;
  logic        last_err;
  logic [7:0]  last_wstrb;
  logic [63:0] last_wdata;
  logic [2:0]  last_awsize;

  axi_store_master dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .st_valid_i      (st_valid),
    .st_ready_o      (st_ready),
    .st_addr_i       (st_addr),
    .st_data_i       (st_data),
    .st_size_i       (st_size),
    .st_done_o       (st_done),
    .st_err_o        (st_err),
    .m_axi_awid_o    (awid),
    .m_axi_awaddr_o  (awaddr),
    .m_axi_awlen_o   (awlen),
    .m_axi_awsize_o  (awsize),
    .m_axi_awburst_o (awburst),
    .m_axi_awlock_o  (awlock),
    .m_axi_awcache_o (awcache),
    .m_axi_awprot_o  (awprot),
    .m_axi_awvalid_o (awvalid),
    .m_axi_awready_i (awready),
    .m_axi_wdata_o   (wdata),
    .m_axi_wstrb_o   (wstrb),
    .m_axi_wlast_o   (wlast),
    .m_axi_wvalid_o  (wvalid),
    .m_axi_wready_i  (wready),
    .m_axi_bid_i     (bid),
    .m_axi_bresp_i   (bresp),
    .m_axi_bvalid_i  (bvalid),
    .m_axi_bready_o  (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: byte i of the right-justified data lands on lane (addr%8)+i.
  task automatic ref_model(input logic [63:0] addr, input logic [63:0] data, input logic [1:0] size,
                           output logic mis, output logic [63:0] exp_wd, output logic [7:0] exp_ws);
    int nb;
    int off;
    nb     = 1 << size;
    off    = int'(addr % 8);
    mis    = (addr % nb) != 0;
    exp_wd = '0;
    exp_ws = '0;
    if (!mis) begin
      for (int i = 0; i < nb; i++) begin
        exp_wd[8*(off+i) +: 8] = data[8*i +: 8];
        exp_ws[off+i]          = 1'b1;
      end
    end
  endtask

  task automatic do_store(input string tag, input logic [63:0] addr, input logic [63:0] data,
                          input logic [1:0] size, input int aw_dly, input int w_dly,
                          input int b_dly, input logic early_b, input logic [1:0] resp);
    logic        mis;
    logic [63:0] exp_wd;
    logic [7:0]  exp_ws;
    int          aw_cyc, w_cyc, b_cyc, done_cyc, n_aw, n_w, wait_cyc, m_cyc, exp_done;
    logic        both;
    ref_model(addr, data, size, mis, exp_wd, exp_ws);
    wait_cyc = 0;
    while (!st_ready && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_eq({tag, ".ready"}, st_ready, 1);
    st_valid = 1'b1;
    st_addr  = addr;
    st_data  = data;
    st_size  = size;
    @(negedge clk);
    st_valid = 1'b0;
    st_addr  = {$urandom, $urandom};
    st_data  = {$urandom, $urandom};
    st_size  = 2'($urandom);
    aw_cyc = 0; w_cyc = 0; b_cyc = 0; done_cyc = 0; n_aw = 0; n_w = 0;
    for (int cyc = 1; cyc <= 100 && done_cyc == 0; cyc++) begin
      both    = (aw_cyc != 0) && (w_cyc != 0);
      m_cyc   = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
      awready = (cyc >= 1 + aw_dly);
      wready  = (cyc >= 1 + w_dly);
      bvalid  = early_b ? (b_cyc == 0) : (both && b_cyc == 0 && cyc >= m_cyc + 1 + b_dly);
      bresp   = resp;
      bid     = 13'($urandom);
      #1;
      if (cyc == 1) begin
        check_eq({tag, ".awv1"}, awvalid, !mis);
        check_eq({tag, ".wv1"}, wvalid, !mis);
      end
      if (!both) check_eq({tag, ".bready_early"}, bready, 0);
      if (awvalid) begin
        check_eq({tag, ".awaddr"}, awaddr, addr);
        check_eq({tag, ".awsize"}, awsize, {1'b0, size});
        check_eq({tag, ".awfix"}, {awid, awlen, awburst, awlock, awcache, awprot},
                 {13'd0, 8'd0, 2'b01, 1'b0, 4'd0, 3'd0});
        last_awsize = awsize;
        if (awready) begin
          n_aw++;
          aw_cyc = cyc;
        end
      end
      if (wvalid) begin
        check_eq({tag, ".wdata"}, wdata, exp_wd);
        check_eq({tag, ".wstrb"}, wstrb, exp_ws);
        check_eq({tag, ".wlast"}, wlast, 1);
        last_wdata = wdata;
        last_wstrb = wstrb;
        if (wready) begin
          n_w++;
          w_cyc = cyc;
        end
      end
      if (bvalid && bready) b_cyc = cyc;
      if (st_done) begin
        done_cyc = cyc;
        last_err = st_err;
        check_eq({tag, ".err"}, st_err, mis | resp[1]);
      end
      @(negedge clk);
    end
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    #1;
    check_eq({tag, ".timeout"}, done_cyc != 0, 1);
    check_eq({tag, ".done_pulse"}, st_done, 0);
    check_eq({tag, ".ready_after"}, st_ready, 1);
    check_eq({tag, ".n_aw"}, n_aw, mis ? 0 : 1);
    check_eq({tag, ".n_w"}, n_w, mis ? 0 : 1);
    if (mis) begin
      exp_done = 1;
    end else begin
      m_cyc    = (aw_dly > w_dly) ? 1 + aw_dly : 1 + w_dly;
      exp_done = m_cyc + 2 + (early_b ? 0 : b_dly);
      check_eq({tag, ".aw_cyc"}, aw_cyc, 1 + aw_dly);
      check_eq({tag, ".w_cyc"}, w_cyc, 1 + w_dly);
    end
    check_eq({tag, ".done_cyc"}, done_cyc, exp_done);
    last_done_cyc = done_cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts, dones, naw;
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;
    repeat (2) @(negedge clk);
    check_eq("rst.ready", st_ready, 1);
    check_eq("rst.ctrl", {st_done, st_err, awvalid, wvalid, bready}, 0);
    check_eq("rst.payload", {awaddr ^ wdata, wstrb}, 0);
    check_eq("rst.wdata", wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_store("sb", 64'h1003, 64'hAB, 2'd0, 0, 0, 0, 1'b0, 2'b00);
    check_eq("sb.wstrb_k", last_wstrb, 8'h08);
    check_eq("sb.wdata_k", last_wdata, 64'h0000_0000_AB00_0000);
    check_eq("sb.awsize_k", last_awsize, 3'd0);
    check_eq("sb.lat_k", last_done_cyc, 3);
    check_eq("sb.err_k", last_err, 0);

    do_store("sd", 64'h2000, 64'h1122_3344_5566_7788, 2'd3, 4, 0, 0, 1'b0, 2'b00);
    check_eq("sd.wstrb_k", last_wstrb, 8'hFF);
    check_eq("sd.lat_k", last_done_cyc, 7);

    do_store("sw_mis", 64'h1002, 64'hDEAD_BEEF, 2'd2, 0, 0, 0, 1'b0, 2'b00);
    check_eq("sw_mis.lat_k", last_done_cyc, 1);
    check_eq("sw_mis.err_k", last_err, 1);

    do_store("sh_slv", 64'h3006, 64'hBEEF, 2'd1, 0, 0, 0, 1'b0, 2'b10);
    check_eq("sh_slv.wstrb_k", last_wstrb, 8'hC0);
    check_eq("sh_slv.wdata_k", last_wdata, 64'hBEEF_0000_0000_0000);
    check_eq("sh_slv.err_k", last_err, 1);

    do_store("early_b", 64'h4010, 64'h55, 2'd2, 2, 1, 0, 1'b1, 2'b11);

    // Back-to-back with st_valid held high.
    awready = 1'b1; wready = 1'b1; bresp = 2'b00;
    st_valid = 1'b1; st_addr = 64'h5008; st_data = 64'h0123; st_size = 2'd3;
    accepts = 0; dones = 0; naw = 0;
    for (int cyc = 0; cyc < 60 && dones < 2; cyc++) begin
      bvalid = bready;
      #1;
      if (st_done) check_eq("b2b.ready_in_done", st_ready, 0);
      if (st_ready && st_valid) accepts++;
      if (awvalid && awready) naw++;
      if (st_done) dones++;
      if (dones == 2) st_valid = 1'b0;
      @(negedge clk);
    end
    st_valid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    check_eq("b2b.dones", dones, 2);
    check_eq("b2b.accepts", accepts, 2);
    check_eq("b2b.aw_hs", naw, 2);

    // Reset while AW/W are pending.
    @(negedge clk);
    st_valid = 1'b1; st_addr = 64'h6000; st_data = 64'h77; st_size = 2'd3;
    @(negedge clk);
    st_valid = 1'b0;
    @(negedge clk);
    check_eq("rstmid.awv_before", awvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstmid.awv", awvalid, 0);
    check_eq("rstmid.wv", wvalid, 0);
    check_eq("rstmid.done", st_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rstmid.after", {st_ready, st_done, awvalid, wvalid, bready}, 5'b10000);
    end

    for (int t = 0; t < 40; t++) begin
      logic [63:0] a;
      logic [1:0]  sz;
      sz = 2'($urandom);
      a  = {$urandom, $urandom};
      if ($urandom_range(3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      do_store($sformatf("rnd%0d", t), a, {$urandom, $urandom}, sz, $urandom_range(3),
               $urandom_range(3), $urandom_range(3), ($urandom_range(7) == 0),
               2'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
